// File: rtl/occ_pkg.sv
// Shared constants, engine state encoding and helpers for
// the multi-phase one-cycle current controller.
package occ_pkg;

   localparam longint SCALE = 1_000_000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAP,
      ST_MUL1,
      ST_MUL2,
      ST_DIV,
      ST_OUT
   } occ_state_e;

   // trigger-to-strobe latency of the shared engine
   function automatic int lat(input int num_w);
      return num_w + 4;
   endfunction

   function automatic int ch_lsb(input int k);
      return 16 * k;
   endfunction

endpackage

// File: rtl/occ_serial_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// The start cycle already performs the first iteration.
import occ_pkg::*;

module occ_serial_divider #(
   parameter int W = 48
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] numer,
   input  logic [W-1:0] denom,
   output logic         done,
   output logic [W-1:0] quotient
);

   localparam int CW = $clog2(W);

   logic [W-1:0]  r_rem;
   logic [W-1:0]  r_q;
   logic [W-1:0]  r_den;
   logic [CW-1:0] r_cnt;
   logic          r_busy;

   logic [W-1:0]  w_rem_in;
   logic [W-1:0]  w_q_in;
   logic [W-1:0]  w_den;
   logic [W:0]    w_try;
   logic [W:0]    w_diff;
   logic          w_sub;

   always_comb begin
      w_rem_in = start ? '0 : r_rem;
      w_q_in   = start ? numer : r_q;
      w_den    = start ? denom : r_den;
      w_try    = {w_rem_in, w_q_in[W-1]};
      w_diff   = w_try - {1'b0, w_den};
      w_sub    = ~w_diff[W];
   end

   assign done     = r_busy && (r_cnt == '0);
   assign quotient = r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem  <= '0;
         r_q    <= '0;
         r_den  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (start || r_busy) begin
         r_den <= w_den;
         r_rem <= w_sub ? w_diff[W-1:0] : w_try[W-1:0];
         r_q   <= {w_q_in[W-2:0], w_sub};
         if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(W - 2);
         end else begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0)
               r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/multi_phase_occ.sv
// N-channel phase-interleaved one-cycle current controller:
// period counter, capture, pipelined multiply, serial divide, clamp.
import occ_pkg::*;

module multi_phase_occ #(
   parameter int N_CH      = 2,
   parameter int VIN       = 120,
   parameter int L_NH      = 3300,
   parameter int FS_KHZ    = 250,
   parameter int TS_CLK    = 400,
   parameter int T_MAX     = 200,
   parameter int I_CH_MAX  = 50,
   parameter int ERR_FLOOR = -5,
   parameter int NUM_W     = 48
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [16*N_CH-1:0]   sample_current,
   input  logic [15:0]          sample_voltage,
   input  logic [15:0]          i_set,
   output logic [15:0]          phase_cnt,
   output logic [16*N_CH-1:0]   t_on,
   output logic [N_CH-1:0]      t_on_valid,
   output logic [N_CH-1:0]      sat,
   output logic                 vgap_fault,
   output logic                 overrun
);

   localparam int SPACING = TS_CLK / N_CH;
   localparam int CH_SH   = $clog2(N_CH);
   localparam int CW      = (N_CH > 1) ? $clog2(N_CH) : 1;

   localparam logic signed [63:0] K_SC  = SCALE;
   localparam logic signed [63:0] K_VIN = 64'(VIN);
   localparam logic signed [63:0] K_TS  = 64'(TS_CLK);
   localparam logic signed [63:0] K_ERR =
      64'(longint'(2) * VIN * L_NH * FS_KHZ);
   localparam logic signed [63:0] K_DEN =
      64'(longint'(2) * VIN * SCALE);
   localparam logic signed [17:0] K_FLOOR = 18'(ERR_FLOOR);

   if (SPACING <= lat(NUM_W)) begin : g_lat_chk
      $error("phase spacing must exceed engine latency");
   end

   occ_state_e              r_state;
   logic [15:0]             r_phase;
   logic [CW-1:0]           r_ch;
   logic [15:0]             r_vg;
   logic signed [17:0]      r_err;
   logic signed [63:0]      r_p1;
   logic signed [63:0]      r_p2;
   logic [NUM_W-1:0]        r_den;
   logic signed [NUM_W-1:0] r_num;
   logic [16*N_CH-1:0]      r_ton;
   logic [N_CH-1:0]         r_tv;
   logic [N_CH-1:0]         r_sat;
   logic                    r_vf;
   logic                    r_ovr;

   logic                    w_trig;
   logic [CW-1:0]           w_trig_ch;
   logic signed [15:0]      w_cur;
   logic [15:0]             w_id;
   logic [15:0]             w_iset_sh;
   logic [15:0]             w_iref;
   logic signed [17:0]      w_err_raw;
   logic signed [17:0]      w_err;
   logic signed [63:0]      w_vg;
   logic signed [63:0]      w_vdiff;
   logic signed [63:0]      w_errx;
   logic signed [NUM_W-1:0] w_num;
   logic                    w_start;
   logic                    w_div_done;
   logic [NUM_W-1:0]        w_q;

   always_comb begin
      w_trig    = 1'b0;
      w_trig_ch = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (r_phase == 16'(k * SPACING)) begin
            w_trig    = en;
            w_trig_ch = CW'(k);
         end
      end
   end

   always_comb begin
      w_cur     = sample_current[ch_lsb(int'(r_ch)) +: 16];
      w_id      = w_cur[15] ? 16'd0 : 16'(w_cur);
      w_iset_sh = i_set >> CH_SH;
      w_iref    = (w_iset_sh > 16'(I_CH_MAX)) ?
                  16'(I_CH_MAX) : w_iset_sh;
      w_err_raw = signed'({2'b00, w_iref}) - signed'({2'b00, w_id});
      w_err     = (w_err_raw < K_FLOOR) ? K_FLOOR : w_err_raw;
      w_vg      = {48'd0, r_vg};
      w_vdiff   = K_VIN - w_vg;
      w_errx    = {{46{r_err[17]}}, r_err};
      w_num     = NUM_W'((r_p1 * K_SC + r_p2) * K_TS);
      w_start   = en && (r_state == ST_MUL2);
   end

   occ_serial_divider #(
      .W (NUM_W)
   ) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (w_start),
      .numer    (w_num),
      .denom    (r_den),
      .done     (w_div_done),
      .quotient (w_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_phase <= '0;
         r_ch    <= '0;
         r_vg    <= '0;
         r_err   <= '0;
         r_p1    <= '0;
         r_p2    <= '0;
         r_den   <= '0;
         r_num   <= '0;
         r_ton   <= '0;
         r_tv    <= '0;
         r_sat   <= '0;
         r_vf    <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_tv <= '0;
         r_vf <= 1'b0;
         if (!en)
            r_phase <= '0;
         else if (r_phase == 16'(TS_CLK - 1))
            r_phase <= '0;
         else
            r_phase <= r_phase + 16'd1;

         if (!en) begin
            r_state <= ST_IDLE;
            r_ton   <= '0;
            r_sat   <= '0;
            r_ovr   <= 1'b0;
         end else begin
            if (w_trig && (r_state != ST_IDLE))
               r_ovr <= 1'b1;
            unique case (r_state)
               ST_IDLE: begin
                  if (w_trig) begin
                     r_ch    <= w_trig_ch;
                     r_state <= ST_CAP;
                  end
               end
               ST_CAP: begin
                  r_vg    <= sample_voltage;
                  r_err   <= w_err;
                  r_state <= ST_MUL1;
               end
               ST_MUL1: begin
                  r_p1    <= w_vg * w_vdiff;
                  r_p2    <= K_ERR * w_errx;
                  r_den   <= NUM_W'(K_DEN * w_vdiff);
                  r_state <= ST_MUL2;
               end
               ST_MUL2: begin
                  r_num   <= w_num;
                  r_state <= ST_DIV;
               end
               ST_DIV: begin
                  if (w_div_done)
                     r_state <= ST_OUT;
               end
               ST_OUT: begin
                  r_state    <= ST_IDLE;
                  r_tv[r_ch] <= 1'b1;
                  // gap at or above the rail makes den meaningless
                  if (r_vg >= 16'(VIN)) begin
                     r_ton[ch_lsb(int'(r_ch)) +: 16] <= '0;
                     r_vf <= 1'b1;
                  end else if (r_num[NUM_W-1] || (r_num == '0)) begin
                     r_ton[ch_lsb(int'(r_ch)) +: 16] <= '0;
                  end else if (w_q > NUM_W'(TS_CLK)) begin
                     r_ton[ch_lsb(int'(r_ch)) +: 16] <= '0;
                     r_sat[r_ch] <= 1'b1;
                  end else if (w_q > NUM_W'(T_MAX)) begin
                     r_ton[ch_lsb(int'(r_ch)) +: 16] <= 16'(T_MAX);
                  end else begin
                     r_ton[ch_lsb(int'(r_ch)) +: 16] <= w_q[15:0];
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign phase_cnt  = r_phase;
   assign t_on       = r_ton;
   assign t_on_valid = r_tv;
   assign sat        = r_sat;
   assign vgap_fault = r_vf;
   assign overrun    = r_ovr;

endmodule

// File: tb/tb_multi_phase_occ.sv
// Scoreboard bench for multi_phase_occ: directed per-period vectors,
// expected strobes queued at stimulus time and checked by a monitor.
module tb_multi_phase_occ;

   localparam int N_CH = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 en;
   logic [16*N_CH-1:0]   sample_current;
   logic [15:0]          sample_voltage;
   logic [15:0]          i_set;
   logic [15:0]          phase_cnt;
   logic [16*N_CH-1:0]   t_on;
   logic [N_CH-1:0]      t_on_valid;
   logic [N_CH-1:0]      sat;
   logic                 vgap_fault;
   logic                 overrun;

   typedef struct {
      int ch;
      int ton;
      int vf;
      int sat;
      int ph;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   multi_phase_occ dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .sample_current (sample_current),
      .sample_voltage (sample_voltage),
      .i_set          (i_set),
      .phase_cnt      (phase_cnt),
      .t_on           (t_on),
      .t_on_valid     (t_on_valid),
      .sat            (sat),
      .vgap_fault     (vgap_fault),
      .overrun        (overrun)
   );

   task automatic chk(input string nm, input longint act,
                      input longint exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic apply(input int vg, input int iset,
                        input int c0, input int c1);
      sample_voltage = 16'(vg);
      i_set          = 16'(iset);
      sample_current = {16'(c1), 16'(c0)};
   endtask

   task automatic push(input int ch, input int ton,
                       input int vf, input int s);
      exp_t x;
      x.ch  = ch;
      x.ton = ton;
      x.vf  = vf;
      x.sat = s;
      x.ph  = ch * 200 + 52;
      q.push_back(x);
   endtask

   task automatic wait_phase(input int p);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (phase_cnt != 16'(p) && n < 2000);
      chk("wait_phase", phase_cnt, p);
   endtask

   task automatic period_end();
      wait_phase(300);
      chk("pending", q.size(), 0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_phase"}, phase_cnt, 0);
      chk({tag, "_t_on"}, t_on, 0);
      chk({tag, "_valid"}, t_on_valid, 0);
      chk({tag, "_sat"}, sat, 0);
      chk({tag, "_vgap"}, vgap_fault, 0);
      chk({tag, "_overrun"}, overrun, 0);
   endtask

   always @(negedge clk) begin
      if (rst_n && (t_on_valid != '0 || vgap_fault)) begin
         if (q.size() == 0) begin
            chk("unexpected_strobe", {vgap_fault, t_on_valid}, 0);
         end else begin
            e = q.pop_front();
            chk("strobe", t_on_valid, 1 << e.ch);
            chk("t_on", t_on[e.ch*16 +: 16], e.ton);
            chk("phase", phase_cnt, e.ph);
            chk("vgap", vgap_fault, e.vf);
            chk("sat", sat, e.sat);
            chk("overrun", overrun, 0);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      apply(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // nominal: err 10 -> 155 on both channels
      apply(60, 40, 10, 10);
      push(0, 155, 0, 0);
      push(1, 155, 0, 0);
      en = 1'b1;
      period_end();

      // i_ref ceiling: q=991 beyond period, sat sticks
      apply(100, 120, 0, 0);
      push(0, 0, 0, 1);
      push(1, 0, 0, 3);
      period_end();

      apply(0, 40, 10, 10);
      push(0, 27, 0, 3);
      push(1, 27, 0, 3);
      period_end();

      // gap exactly at the rail, then above it
      apply(120, 40, 10, 10);
      push(0, 0, 1, 3);
      push(1, 0, 1, 3);
      period_end();

      apply(130, 40, 10, 10);
      push(0, 0, 1, 3);
      push(1, 0, 1, 3);
      period_end();

      // negative numerator
      apply(1, 40, 25, 25);
      push(0, 0, 0, 3);
      push(1, 0, 0, 3);
      period_end();

      // floored err on ch0, negative current -> T_MAX on ch1
      apply(60, 40, 25, -7);
      push(0, 72, 0, 3);
      push(1, 200, 0, 3);
      period_end();

      // drop enable mid-divide
      apply(60, 40, 10, 10);
      wait_phase(20);
      en = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("abort");
      repeat (60) @(negedge clk);
      chk("abort_pending", q.size(), 0);
      push(0, 155, 0, 0);
      push(1, 155, 0, 0);
      en = 1'b1;
      period_end();

      // asynchronous reset mid-divide
      wait_phase(20);
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      repeat (2) @(negedge clk);
      push(0, 155, 0, 0);
      push(1, 155, 0, 0);
      rst_n = 1'b1;
      period_end();

      repeat (5) @(negedge clk);
      chk("final_pending", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
